// File: rtl/matrix_mult_top_if.sv
// rtl/matrix_mult_top_if.sv - host-side load/readout bundle of the matrix-multiply accelerator
interface matrix_mult_top_if;
  logic       start_in;
  logic       valid_input;
  logic [7:0] X_load;
  logic       read_n;
  logic [7:0] r_addr;
  logic       ry;
  logic [8:0] data_out;
  logic       finish;

  modport master (
    output start_in, valid_input, X_load, read_n, r_addr,
    input  ry, data_out, finish
  );

  modport slave (
    input  start_in, valid_input, X_load, read_n, r_addr,
    output ry, data_out, finish
  );
endinterface

// File: rtl/matrix_mult_top.sv
// rtl/matrix_mult_top.sv - 4x8 by constant 8x4 matrix multiply with double-banked result RAM
module matrix_mult_top (
  input  logic              clk,
  input  logic              rst,
  matrix_mult_top_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  // A[k][j] = 4k + j + 1, small enough to be generated instead of stored
  function automatic logic [6:0] coef(input logic [2:0] k, input logic [1:0] j);
    return {2'b00, k, 2'b00} + {5'd0, j} + 7'd1;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  load_cnt_q, load_cnt_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic        bank_q, bank_d;
  logic        finish_q, finish_d;
  logic [17:0] acc_q [4];
  logic [17:0] acc_d [4];

  logic [7:0]  x_q [32];
  logic [17:0] ram [32];

  logic        x_we;
  logic        ram_we;
  logic [4:0]  ram_waddr;
  logic [17:0] ram_wdata;
  logic [7:0]  x_sel;

  logic [1:0]  rd_cnt_q;
  logic [4:0]  raddr_q;
  logic [17:0] word_q;
  logic [8:0]  data_out_q;

  // Upper address bits select nothing; the RAM is only 32 words deep
  logic [2:0]  unused_addr_bits;
  assign unused_addr_bits = bus.r_addr[7:5];

  assign x_sel = x_q[{row_q, k_q}];

  // Next-state logic: load, per-row MAC over k, then four result writes per row
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    bank_d     = bank_q;
    finish_d   = finish_q;
    for (int j = 0; j < 4; j++) acc_d[j] = acc_q[j];
    x_we       = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = {bank_q, row_q, col_q};
    ram_wdata  = acc_q[col_q];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_in) begin
          state_d    = S_LOAD;
          finish_d   = 1'b0;
          load_cnt_d = 5'd0;
        end
      end
      S_LOAD: begin
        if (bus.valid_input) begin
          x_we       = 1'b1;
          load_cnt_d = load_cnt_q + 5'd1;
          if (load_cnt_q == 5'd31) begin
            state_d = S_COMPUTE;
            k_d     = 3'd0;
            row_d   = 2'd0;
          end
        end
      end
      S_COMPUTE: begin
        // k == 0 restarts the accumulators so no separate clear cycle is needed
        for (int j = 0; j < 4; j++) begin
          acc_d[j] = ((k_q == 3'd0) ? 18'd0 : acc_q[j])
                   + 18'(x_sel) * 18'(coef(k_q, 2'(j)));
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = S_WRITE;
          col_d   = 2'd0;
        end
      end
      S_WRITE: begin
        ram_we = 1'b1;
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) begin
          if (row_q == 2'd3) begin
            state_d  = S_DONE;
            finish_d = 1'b1;
            bank_d   = ~bank_q;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = S_COMPUTE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= 5'd0;
      k_q        <= 3'd0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      bank_q     <= 1'b0;
      finish_q   <= 1'b0;
      for (int j = 0; j < 4; j++) acc_q[j] <= 18'd0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
      bank_q     <= bank_d;
      finish_q   <= finish_d;
      for (int j = 0; j < 4; j++) acc_q[j] <= acc_d[j];
    end
  end

  // Input matrix storage, row-major by byte index
  always_ff @(posedge clk) begin
    if (x_we && !rst) x_q[load_cnt_q] <= bus.X_load;
  end

  // Result RAM write port; contents survive reset but reset blocks the write
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[ram_waddr] <= ram_wdata;
  end

  // Readout: latch address, fetch word + low half, then high half; rd_cnt_q also spaces requests 4 apart
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= 2'd0;
      raddr_q    <= 5'd0;
      word_q     <= 18'd0;
      data_out_q <= 9'd0;
    end else begin
      if (rd_cnt_q == 2'd0) begin
        if (!bus.read_n) begin
          raddr_q  <= bus.r_addr[4:0];
          rd_cnt_q <= 2'd3;
        end
      end else begin
        rd_cnt_q <= rd_cnt_q - 2'd1;
      end
      if (rd_cnt_q == 2'd3) begin
        word_q     <= ram[raddr_q];
        data_out_q <= ram[raddr_q][8:0];
      end
      if (rd_cnt_q == 2'd2) begin
        data_out_q <= word_q[17:9];
      end
    end
  end

  assign bus.ry       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.finish   = finish_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_matrix_mult_top.sv
// tb/tb_matrix_mult_top.sv - randomized self-checking bench for matrix_mult_top
module tb_matrix_mult_top;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mult_top_if bus ();

  matrix_mult_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] xb [32];
  int         mem [32];
  int         base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain matrix product with A[k][j] = 4k+j+1, stored to the current bank
  task automatic model_commit();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(xb[i*8+k]) * (4*k + j + 1);
        mem[base + 4*i + j] = s;
      end
    base = (base == 0) ? 16 : 0;
  endtask

  task automatic send_bytes(input int stall_at, input int stall_len, output int total);
    @(negedge clk); bus.start_in = 1'b1;
    @(negedge clk); bus.start_in = 1'b0;
    total = 0;
    check("ry_low_in_load", 32'(bus.ry), 32'd0);
    check("finish_cleared", 32'(bus.finish), 32'd0);
    for (int n = 0; n < 32; n++) begin
      if (n == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.valid_input = 1'b0;
          @(negedge clk); total++;
        end
      end
      bus.valid_input = 1'b1;
      bus.X_load      = xb[n];
      @(negedge clk); total++;
    end
    bus.valid_input = 1'b0;
  endtask

  task automatic run_matrix(input int stall_at, input int stall_len, output int lat, output int total);
    send_bytes(stall_at, stall_len, total);
    lat = 0;
    while (!bus.finish && lat < 200) begin
      @(negedge clk); lat++;
    end
    total += lat;
    check("ry_in_done", 32'(bus.ry), 32'd1);
    model_commit();
  endtask

  task automatic read_word(input int a, output logic [8:0] lo, output logic [8:0] hi);
    @(negedge clk); bus.read_n = 1'b0; bus.r_addr = {3'($urandom), 5'(a)};
    @(negedge clk); bus.read_n = 1'b1;
    @(negedge clk); lo = bus.data_out;
    @(negedge clk); hi = bus.data_out;
    @(negedge clk);
  endtask

  task automatic read_check(input int a);
    logic [8:0] lo, hi;
    read_word(a, lo, hi);
    check($sformatf("lo[%0d]", a), 32'(lo), 32'(mem[a] % 512));
    check($sformatf("hi[%0d]", a), 32'(hi), 32'(mem[a] / 512));
  endtask

  task automatic read_bank(input int b);
    for (int a = b; a < b + 16; a++) read_check(a);
  endtask

  initial begin
    int lat, total;
    logic [8:0] lo, hi;
    int rb;

    base            = 0;
    rst             = 1'b1;
    bus.start_in    = 1'b0;
    bus.valid_input = 1'b0;
    bus.X_load      = 8'd0;
    bus.read_n      = 1'b1;
    bus.r_addr      = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_ry", 32'(bus.ry), 32'd1);
    check("rst_data_out", 32'(bus.data_out), 32'd0);

    // All ones into bank 0
    for (int n = 0; n < 32; n++) xb[n] = 8'h01;
    run_matrix(-1, 0, lat, total);
    check("lat_ones", 32'(lat), 32'd48);
    check("total_ones", 32'(total), 32'd80);
    read_bank(0);

    // All 0xFF into bank 16, plus the extreme entry by hand
    for (int n = 0; n < 32; n++) xb[n] = 8'hFF;
    run_matrix(-1, 0, lat, total);
    check("lat_ff", 32'(lat), 32'd48);
    read_bank(16);
    read_word(19, lo, hi);
    check("addr19_lo", 32'(lo), 32'd368);
    check("addr19_hi", 32'(hi), 32'd71);

    // Identity-like selector wraps back to bank 0
    for (int n = 0; n < 32; n++) xb[n] = ((n % 8) == (n / 8)) ? 8'd1 : 8'd0;
    run_matrix(-1, 0, lat, total);
    read_bank(0);
    read_bank(16);

    // Random data with a 5-cycle stall mid-load
    for (int n = 0; n < 32; n++) xb[n] = 8'($urandom);
    run_matrix($urandom_range(1, 30), 5, lat, total);
    check("lat_stall", 32'(lat), 32'd48);
    check("total_stall", 32'(total), 32'd85);
    read_bank(16);

    // A couple of unstalled random matrices
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 32; n++) xb[n] = 8'($urandom);
      run_matrix(-1, 0, lat, total);
      check("total_rand", 32'(total), 32'd80);
      read_bank(base == 0 ? 16 : 0);
    end

    // Reset in the middle of COMPUTE, then a fresh load lands in bank 0
    for (int n = 0; n < 32; n++) xb[n] = 8'($urandom);
    send_bytes(-1, 0, total);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_finish", 32'(bus.finish), 32'd0);
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_ry", 32'(bus.ry), 32'd1);
    base = 0;
    for (int n = 0; n < 32; n++) xb[n] = 8'($urandom);
    run_matrix(-1, 0, lat, total);
    check("lat_after_rst", 32'(lat), 32'd48);
    read_bank(0);

    // A second request two cycles after the first is ignored
    @(negedge clk); bus.read_n = 1'b0; bus.r_addr = 8'd4;
    @(negedge clk); bus.read_n = 1'b1;
    @(negedge clk); bus.read_n = 1'b0; bus.r_addr = 8'd5;
    check("b2b_lo", 32'(bus.data_out), 32'(mem[4] % 512));
    @(negedge clk); bus.read_n = 1'b1;
    check("b2b_hi", 32'(bus.data_out), 32'(mem[4] / 512));
    rb = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.data_out !== 9'(mem[4] / 512)) rb++;
    end
    check("b2b_hold", 32'(rb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
